// File: rtl/serializer.sv
// Parallel-to-serial converter: one-word holding register feeding a LENGTH-bit
// shifter, LSB first, with o_dout_last marking the final bit of each word.
module serializer #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [LENGTH-1:0] iv_din,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  output logic              o_dout,
  output logic              o_dout_valid,
  output logic              o_dout_last,
  output logic              o_busy
);

  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            r_state, w_state_nxt;
  logic [LENGTH-1:0] r_hold;
  logic              r_hold_full;
  logic [LENGTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_dout, r_dout_valid, r_dout_last;
  logic              w_dout_nxt, w_vld_nxt, w_last_nxt;
  logic              w_unload, w_accept;

  // Ready comes from the registered full flag, so accept and unload are exclusive.
  assign o_din_ready  = i_rst_n & ~r_hold_full;
  assign w_accept     = i_din_valid & o_din_ready;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_dout_last  = r_dout_last;
  assign o_busy       = (r_state == SHIFT) | r_hold_full;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = 1'b0;
    w_vld_nxt   = 1'b0;
    w_last_nxt  = 1'b0;
    w_unload    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_unload    = 1'b1;
          w_dout_nxt  = r_hold[0];
          w_vld_nxt   = 1'b1;
          w_shift_nxt = r_hold >> 1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_dout_nxt = r_shift[0];
        w_vld_nxt  = 1'b1;
        if (r_cnt == LAST) begin
          w_last_nxt = 1'b1;
          w_cnt_nxt  = '0;
          // Chain straight into the held word so the next enabled bit is its bit 0.
          if (r_hold_full) begin
            w_unload    = 1'b1;
            w_shift_nxt = r_hold;
          end else begin
            w_shift_nxt = '0;
            w_state_nxt = IDLE;
          end
        end else begin
          w_shift_nxt = r_shift >> 1;
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold      <= iv_din;
        r_hold_full <= 1'b1;
      end else if (i_en && w_unload) begin
        r_hold_full <= 1'b0;
      end
      if (i_en) begin
        r_state      <= w_state_nxt;
        r_shift      <= w_shift_nxt;
        r_cnt        <= w_cnt_nxt;
        r_dout       <= w_dout_nxt;
        r_dout_valid <= w_vld_nxt;
        r_dout_last  <= w_last_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;

  localparam int L = 24;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_en;
  logic [L-1:0] iv_din;
  logic         i_din_valid;
  logic         o_din_ready, o_dout, o_dout_valid, o_dout_last, o_busy;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  serializer #(.LENGTH(L)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .iv_din      (iv_din),
    .i_din_valid (i_din_valid),
    .o_din_ready (o_din_ready),
    .o_dout      (o_dout),
    .o_dout_valid(o_dout_valid),
    .o_dout_last (o_dout_last),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [1:0]   bq[$];
  logic [L-1:0] wq[$];

  int en_mode = 0;
  int cyc = 0;
  initial begin
    i_en = 1'b1;
    forever begin
      @(negedge i_clk);
      cyc++;
      case (en_mode)
        0:       i_en = 1'b1;
        1:       i_en = (cyc % 3 == 0);
        default: i_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic         en_s;
  logic [2:0]   prev_out = '0;
  logic [L-1:0] acc;
  logic [1:0]   exp_b;
  logic [L-1:0] exp_w;
  int idx = 0, run = 0, max_run = 0, vld_clks = 0, bits_seen = 0;
  initial begin
    forever begin
      @(posedge i_clk);
      en_s = i_en;
      #1;
      if (!i_rst_n) begin
        idx = 0;
        run = 0;
      end else if (!en_s) begin
        chk("hold_when_disabled", {o_dout, o_dout_valid, o_dout_last}, prev_out);
      end else if (o_dout_valid) begin
        run++;
        if (run > max_run) max_run = run;
        bits_seen++;
        chk("unexpected_bit", (bq.size() != 0), 1'b1);
        if (bq.size() != 0) begin
          exp_b = bq.pop_front();
          chk("dout", o_dout, exp_b[0]);
          chk("dout_last", o_dout_last, exp_b[1]);
        end
        acc[idx] = o_dout;
        idx++;
        if (o_dout_last || idx == L) begin
          chk("word_len", idx, L);
          if (wq.size() != 0) begin
            exp_w = wq.pop_front();
            chk("word", acc, exp_w);
          end
          idx = 0;
        end
      end else begin
        run = 0;
      end
      if (o_dout_valid) vld_clks++;
      prev_out = {o_dout, o_dout_valid, o_dout_last};
    end
  end

  task automatic push_word(input logic [L-1:0] w);
    for (int i = 0; i < L; i++) bq.push_back({(i == L - 1), w[i]});
    wq.push_back(w);
  endtask

  task automatic send(input logic [L-1:0] w);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_din_ready && n < 2000);
    chk("send_ready_timeout", o_din_ready, 1'b1);
    iv_din      = w;
    i_din_valid = 1'b1;
    push_word(w);
    @(posedge i_clk);
    #1;
    chk("accept_sets_full", o_din_ready, 1'b0);
    i_din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(posedge i_clk);
      #2;
      if (bq.size() == 0 && !o_dout_valid && !o_busy) done = 1'b1;
    end
    chk("idle_timeout", done, 1'b1);
  endtask

  initial begin
    logic [L-1:0] w;
    int n;
    i_rst_n     = 1'b1;
    iv_din      = '0;
    i_din_valid = 1'b0;
    #1 i_rst_n = 1'b0;
    #2;
    chk("rst_dout", o_dout, 1'b0);
    chk("rst_valid", o_dout_valid, 1'b0);
    chk("rst_last", o_dout_last, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_din_ready, 1'b0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ready_after_rst", o_din_ready, 1'b1);

    en_mode = 0;
    @(negedge i_clk);
    send(24'hA5C30F);
    chk("busy_single", o_busy, 1'b1);
    wait_idle();
    chk("idle_valid", o_dout_valid, 1'b0);

    max_run = 0;
    send(24'h000001);
    send(24'h800000);
    chk("ready_while_held", o_din_ready, 1'b0);
    chk("busy_while_held", o_busy, 1'b1);
    wait_idle();
    chk("b2b_run", max_run, 48);

    en_mode = 1;
    repeat (6) @(negedge i_clk);
    vld_clks = 0;
    max_run  = 0;
    send(24'h00000F);
    wait_idle();
    chk("slow_frame_clocks", vld_clks, 72);
    chk("slow_run", max_run, 24);

    en_mode = 0;
    repeat (2) @(negedge i_clk);
    bits_seen = 0;
    send(24'h00FFF0);
    send(24'h3C3C3C);
    n = 0;
    while (bits_seen < 10 && n < 200) begin
      @(posedge i_clk);
      #2;
      n++;
    end
    chk("bit10_timeout", bits_seen, 10);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", o_dout, 1'b0);
    chk("mid_rst_valid", o_dout_valid, 1'b0);
    chk("mid_rst_last", o_dout_last, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_ready", o_din_ready, 1'b0);
    bq.delete();
    wq.delete();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ready_after_mid_rst", o_din_ready, 1'b1);
    repeat (30) @(posedge i_clk);
    #1;
    chk("no_stale_busy", o_busy, 1'b0);
    send(24'h123456);
    wait_idle();

    n = 0;
    while (n < 100) begin
      @(negedge i_clk);
      if (o_din_ready) begin
        w = L'($urandom);
        iv_din      = w;
        i_din_valid = 1'b1;
        push_word(w);
        n++;
      end
    end
    @(negedge i_clk);
    i_din_valid = 1'b0;
    wait_idle();
    chk("stream_words_left", wq.size(), 0);

    en_mode = 2;
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 30)) @(negedge i_clk);
      send(L'($urandom));
    end
    wait_idle();
    chk("loop_words_left", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
